// File: rtl/avm_read_prefetcher_pkg.sv
// Shared types and constants for the Avalon-MM read prefetcher.
package avm_prefetch_pkg;

  // Controller states: idle, issuing reads, waiting for the consumer, completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Byte distance between consecutive 32-bit words.
  localparam int ADDR_STRIDE = 4;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_COUNT_WIDTH = 19;
  localparam int DEF_FIFO_DEPTH  = 8;

endpackage

// File: rtl/avm_read_prefetcher_if.sv
// Control, stream and Avalon-MM master signals of the prefetcher.
// The master modport is the prefetcher's view (it masters the Avalon bus and
// sources the stream); the slave modport is the surrounding system's view.
interface avm_read_prefetcher_if #(
  parameter int DATA_WIDTH  = avm_prefetch_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = avm_prefetch_pkg::DEF_ADDR_WIDTH,
  parameter int COUNT_WIDTH = avm_prefetch_pkg::DEF_COUNT_WIDTH
);
  // control
  logic                   start;
  logic                   abort;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [COUNT_WIDTH-1:0] word_count;
  logic                   busy;
  logic                   done;
  // stream to the datapath
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   data_valid;
  logic                   data_ready;
  // Avalon-MM read master
  logic [ADDR_WIDTH-1:0]  avm_avalonmaster_address;
  logic                   avm_avalonmaster_read;
  logic                   avm_avalonmaster_waitrequest;
  logic [DATA_WIDTH-1:0]  avm_avalonmaster_readdata;

  modport master (
    input  start, abort, base_addr, word_count, data_ready,
           avm_avalonmaster_waitrequest, avm_avalonmaster_readdata,
    output busy, done, data_out, data_valid,
           avm_avalonmaster_address, avm_avalonmaster_read
  );

  modport slave (
    output start, abort, base_addr, word_count, data_ready,
           avm_avalonmaster_waitrequest, avm_avalonmaster_readdata,
    input  busy, done, data_out, data_valid,
           avm_avalonmaster_address, avm_avalonmaster_read
  );
endinterface

// File: rtl/avm_read_prefetcher_fifo.sv
// Small synchronous FIFO with a registered head word, occupancy count and flush.
// Push and pop may happen together at any occupancy, including full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_eff, pop_eff;

  // Next pointers, count and head word; the head is refilled from storage on pop
  // or taken straight from the push data when the FIFO is (becoming) empty.
  always_comb begin
    pop_eff    = pop_i && (count_q != '0);
    push_eff   = push_i && ((count_q != FULL_C) || pop_eff);
    rd_ptr_inc = rd_ptr_q + AW'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_inc;
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_eff && ((count_q == '0) || (pop_eff && (count_q == CW'(1)))))
        head_d = push_data_i;
      else if (pop_eff && (count_q > CW'(1)))
        head_d = mem_q[rd_ptr_inc];
    end
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_eff && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/avm_read_prefetcher.sv
// Block read front-end: fetches word_count words from base_addr over Avalon-MM,
// buffers them and streams them to the accumulate datapath.
module avm_read_prefetcher
  import avm_prefetch_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic                   csi_clock_clk,
  input logic                   csi_clock_reset_n,
  avm_read_prefetcher_if.master bus
);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FIFO_CW-1:0]    FIFO_FULL = FIFO_CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] issued_q, issued_d, issued_inc;
  logic                   abort_q, abort_d;   // abort seen while a read was stalled

  logic [FIFO_CW-1:0]     fifo_count;
  logic [DATA_WIDTH-1:0]  fifo_head;
  logic                   fifo_push, fifo_pop, fifo_flush;
  logic                   rd_en, accept, abort_req, data_valid;

  // read depends only on state and FIFO occupancy registers, never on waitrequest,
  // so it cannot drop while a stalled transfer waits (occupancy cannot rise then).
  assign rd_en      = (state_q == ST_FETCH) && (fifo_count < FIFO_FULL);
  assign accept     = rd_en && !bus.avm_avalonmaster_waitrequest;
  assign abort_req  = abort_q || bus.abort;
  assign issued_inc = issued_q + COUNT_WIDTH'(1);
  assign data_valid = (fifo_count != '0);
  assign fifo_pop   = data_valid && bus.data_ready;

  // Next-state and datapath control; defaults hold every register.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    total_d    = total_q;
    issued_d   = issued_q;
    abort_d    = abort_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d   = bus.base_addr;
          total_d  = bus.word_count;
          issued_d = '0;
          abort_d  = 1'b0;
          state_d  = (bus.word_count != '0) ? ST_FETCH : ST_FINISH;
        end
      end
      ST_FETCH: begin
        if (abort_req) begin
          if (rd_en && bus.avm_avalonmaster_waitrequest) begin
            // let the outstanding read complete; its data is dropped later
            abort_d = 1'b1;
          end else begin
            abort_d    = 1'b0;
            fifo_flush = 1'b1;
            state_d    = ST_FINISH;
          end
        end else if (accept) begin
          fifo_push = 1'b1;
          addr_d    = addr_q + STRIDE;
          issued_d  = issued_inc;
          if (issued_inc == total_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          fifo_flush = 1'b1;
          state_d    = ST_FINISH;
        end else if (fifo_count == '0) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
    if (!csi_clock_reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      total_q  <= '0;
      issued_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      total_q  <= total_d;
      issued_q <= issued_d;
      abort_q  <= abort_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (FIFO_CW)
  ) u_fifo (
    .clk         (csi_clock_clk),
    .rst_n       (csi_clock_reset_n),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (bus.avm_avalonmaster_readdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign bus.avm_avalonmaster_read    = rd_en;
  assign bus.avm_avalonmaster_address = addr_q;
  assign bus.busy                     = (state_q != ST_IDLE);
  assign bus.done                     = (state_q == ST_FINISH);
  assign bus.data_out                 = fifo_head;
  assign bus.data_valid               = data_valid;

endmodule

// File: tb/tb_avm_read_prefetcher.sv
// Directed bench for avm_read_prefetcher: memory model returns address ^ 0xDEAD0000.
module tb_avm_read_prefetcher;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vec = 0;
  int   miss = 0;

  avm_read_prefetcher_if bus ();

  avm_read_prefetcher dut (
    .csi_clock_clk     (clk),
    .csi_clock_reset_n (rst_n),
    .bus               (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.avm_avalonmaster_readdata = bus.avm_avalonmaster_address ^ 32'hDEAD_0000;

  // observation log
  logic [31:0] acc_addr [$];
  logic [31:0] pop_data [$];
  logic [31:0] stall_addr [$];
  int          acc_cyc [$];
  int          n_acc, n_read_cyc, n_busy, n_done;
  int          first_valid_cyc, last_pop_cyc, done_cyc, start_cyc;
  logic        valid_at_done;
  int          stall_idx, stall_left;
  bit          hold_wait;

  // Slave model and monitor: waitrequest set at negedge+1, everything sampled at negedge+2.
  always begin
    logic wreq;
    @(negedge clk);
    #1;
    wreq = 1'b0;
    if (hold_wait) wreq = 1'b1;
    else if (bus.avm_avalonmaster_read === 1'b1 && n_acc == stall_idx && stall_left > 0) begin
      wreq = 1'b1;
      stall_left--;
      stall_addr.push_back(bus.avm_avalonmaster_address);
    end
    bus.avm_avalonmaster_waitrequest = wreq;
    #1;
    if (bus.avm_avalonmaster_read === 1'b1) n_read_cyc++;
    if (bus.avm_avalonmaster_read === 1'b1 && !wreq) begin
      acc_addr.push_back(bus.avm_avalonmaster_address);
      acc_cyc.push_back(cyc);
      n_acc++;
    end
    if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      pop_data.push_back(bus.data_out);
      last_pop_cyc = cyc;
    end
    if (bus.data_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.busy === 1'b1) n_busy++;
    if (bus.done === 1'b1) begin
      n_done++;
      done_cyc      = cyc;
      valid_at_done = bus.data_valid;
    end
  end

  task automatic clear_log();
    acc_addr.delete();
    pop_data.delete();
    stall_addr.delete();
    acc_cyc.delete();
    n_acc = 0; n_read_cyc = 0; n_busy = 0; n_done = 0;
    first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    stall_idx = -1; stall_left = 0; hold_wait = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [31:0] addr, input logic [18:0] cnt);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = addr;
    bus.word_count = cnt;
    start_cyc      = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (n_done > 0) begin seen = 1'b1; break; end
    end
    vec++;
    if (!seen) begin
      miss++;
      $display("FAIL wait_done: no done pulse within %0d cycles (required one)", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vec++; if (bus.done !== 1'b0) begin miss++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vec++; if (bus.data_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b want 0", bus.data_valid); end
    vec++; if (bus.data_out !== 32'h0) begin miss++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
    vec++; if (bus.avm_avalonmaster_read !== 1'b0) begin miss++; $display("FAIL reset_read: got %b want 0", bus.avm_avalonmaster_read); end
    vec++; if (bus.avm_avalonmaster_address !== 32'h0) begin miss++; $display("FAIL reset_addr: got %h want 0", bus.avm_avalonmaster_address); end
    rst_n = 1'b1;
    idle(2);
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_basic_stream();
    logic [31:0] exp_a [4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
    logic [31:0] exp_d [4] = '{32'hDEAD_1000, 32'hDEAD_1004, 32'hDEAD_1008, 32'hDEAD_100C};
    clear_log();
    bus.data_ready = 1'b1;
    do_start(32'h1000, 19'd4);
    wait_done(40);
    idle(3);
    vec++; if (n_acc != 4) begin miss++; $display("FAIL basic_reads: got %0d want 4", n_acc); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (acc_addr[i] !== exp_a[i]) begin miss++; $display("FAIL basic_addr[%0d]: got %h want %h", i, acc_addr[i], exp_a[i]); end
      vec++; if (acc_cyc[i] != start_cyc + 1 + i) begin miss++; $display("FAIL basic_read_cyc[%0d]: got %0d want %0d", i, acc_cyc[i], start_cyc + 1 + i); end
      vec++; if (pop_data[i] !== exp_d[i]) begin miss++; $display("FAIL basic_data[%0d]: got %h want %h", i, pop_data[i], exp_d[i]); end
    end
    vec++; if (pop_data.size() != 4) begin miss++; $display("FAIL basic_pops: got %0d want 4", pop_data.size()); end
    vec++; if (first_valid_cyc != start_cyc + 2) begin miss++; $display("FAIL basic_first_valid: got %0d want %0d", first_valid_cyc, start_cyc + 2); end
    vec++; if (done_cyc != last_pop_cyc + 2) begin miss++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, last_pop_cyc + 2); end
    vec++; if (n_done != 1) begin miss++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
    $display("basic: 4 words from 0x1000, %0d pops, done at cycle %0d", pop_data.size(), done_cyc);
  endtask

  task automatic test_waitrequest_stall();
    clear_log();
    bus.data_ready = 1'b1;
    stall_idx  = 1;
    stall_left = 3;
    do_start(32'h1000, 19'd4);
    wait_done(40);
    idle(3);
    vec++; if (stall_addr.size() != 3) begin miss++; $display("FAIL stall_cycles: got %0d want 3", stall_addr.size()); end
    foreach (stall_addr[i]) begin
      vec++; if (stall_addr[i] !== 32'h1004) begin miss++; $display("FAIL stall_addr[%0d]: got %h want 00001004", i, stall_addr[i]); end
    end
    vec++; if (n_acc != 4) begin miss++; $display("FAIL stall_reads: got %0d want 4", n_acc); end
    vec++; if (acc_cyc[1] != acc_cyc[0] + 4) begin miss++; $display("FAIL stall_accept_cyc: got %0d want %0d", acc_cyc[1], acc_cyc[0] + 4); end
    vec++; if (pop_data.size() != 4) begin miss++; $display("FAIL stall_pops: got %0d want 4", pop_data.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = 32'hDEAD_1000 + 32'(4 * i);
      vec++; if (pop_data[i] !== e) begin miss++; $display("FAIL stall_data[%0d]: got %h want %h", i, pop_data[i], e); end
    end
    $display("stall: 3 wait cycles on 0x1004, %0d words delivered", pop_data.size());
  endtask

  task automatic test_backpressure();
    clear_log();
    bus.data_ready = 1'b0;
    do_start(32'h4000, 19'd20);
    idle(30);
    vec++; if (n_acc != 8) begin miss++; $display("FAIL bp_reads_full: got %0d want 8", n_acc); end
    vec++; if (n_read_cyc != 8) begin miss++; $display("FAIL bp_read_cycles: got %0d want 8", n_read_cyc); end
    vec++; if (bus.avm_avalonmaster_read !== 1'b0) begin miss++; $display("FAIL bp_read_low: got %b want 0", bus.avm_avalonmaster_read); end
    vec++; if (bus.data_out !== 32'hDEAD_4000) begin miss++; $display("FAIL bp_head: got %h want dead4000", bus.data_out); end
    bus.data_ready = 1'b1;
    wait_done(200);
    idle(3);
    vec++; if (n_acc != 20) begin miss++; $display("FAIL bp_reads_total: got %0d want 20", n_acc); end
    vec++; if (pop_data.size() != 20) begin miss++; $display("FAIL bp_pops: got %0d want 20", pop_data.size()); end
    for (int i = 0; i < 20; i++) begin
      logic [31:0] e;
      e = 32'hDEAD_4000 + 32'(4 * i);
      vec++; if (pop_data[i] !== e) begin miss++; $display("FAIL bp_data[%0d]: got %h want %h", i, pop_data[i], e); end
    end
    $display("backpressure: 8 reads while stalled, %0d words total", pop_data.size());
  endtask

  task automatic test_zero_count();
    clear_log();
    bus.data_ready = 1'b1;
    do_start(32'h8000, 19'd0);
    wait_done(10);
    idle(3);
    vec++; if (n_read_cyc != 0) begin miss++; $display("FAIL zero_reads: got %0d want 0", n_read_cyc); end
    vec++; if (n_busy != 1) begin miss++; $display("FAIL zero_busy_cycles: got %0d want 1", n_busy); end
    vec++; if (n_done != 1) begin miss++; $display("FAIL zero_done_count: got %0d want 1", n_done); end
    vec++; if (done_cyc != start_cyc + 1) begin miss++; $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc, start_cyc + 1); end
    $display("zero_count: busy %0d cycle(s), done at cycle %0d", n_busy, done_cyc);
  endtask

  task automatic test_abort_stalled();
    clear_log();
    bus.data_ready = 1'b0;
    stall_idx  = 2;
    stall_left = 1000;
    do_start(32'h2000, 19'd8);
    idle(5);
    vec++; if (n_acc != 2) begin miss++; $display("FAIL abort_pre_reads: got %0d want 2", n_acc); end
    vec++; if (bus.avm_avalonmaster_read !== 1'b1) begin miss++; $display("FAIL abort_pending_read: got %b want 1", bus.avm_avalonmaster_read); end
    bus.abort = 1'b1;
    idle(3);
    vec++; if (bus.avm_avalonmaster_address !== 32'h2008) begin miss++; $display("FAIL abort_held_addr: got %h want 00002008", bus.avm_avalonmaster_address); end
    vec++; if (bus.avm_avalonmaster_read !== 1'b1) begin miss++; $display("FAIL abort_held_read: got %b want 1", bus.avm_avalonmaster_read); end
    stall_left = 0;
    wait_done(20);
    bus.abort = 1'b0;
    idle(4);
    vec++; if (n_acc != 3) begin miss++; $display("FAIL abort_reads: got %0d want 3", n_acc); end
    vec++; if (acc_addr[2] !== 32'h2008) begin miss++; $display("FAIL abort_last_addr: got %h want 00002008", acc_addr[2]); end
    vec++; if (n_read_cyc != n_acc + stall_addr.size()) begin miss++; $display("FAIL abort_extra_reads: got %0d read cycles want %0d", n_read_cyc, n_acc + stall_addr.size()); end
    vec++; if (valid_at_done !== 1'b0) begin miss++; $display("FAIL abort_valid_at_done: got %b want 0", valid_at_done); end
    vec++; if (bus.data_valid !== 1'b0) begin miss++; $display("FAIL abort_valid_after: got %b want 0", bus.data_valid); end
    vec++; if (n_done != 1) begin miss++; $display("FAIL abort_done_count: got %0d want 1", n_done); end
    vec++; if (pop_data.size() != 0) begin miss++; $display("FAIL abort_pops: got %0d want 0", pop_data.size()); end
    $display("abort: %0d reads, pending read held %0d cycles, done at cycle %0d", n_acc, stall_addr.size(), done_cyc);
  endtask

  task automatic test_wrap_and_restart();
    logic [31:0] exp_a [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    logic [31:0] exp_d [4] = '{32'h2152_FFF8, 32'h2152_FFFC, 32'hDEAD_0000, 32'hDEAD_0004};
    clear_log();
    bus.data_ready = 1'b1;
    do_start(32'hFFFF_FFF8, 19'd4);
    bus.start      = 1'b1;
    bus.base_addr  = 32'h3000;
    bus.word_count = 19'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(30);
    idle(6);
    vec++; if (n_acc != 4) begin miss++; $display("FAIL wrap_reads: got %0d want 4", n_acc); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (acc_addr[i] !== exp_a[i]) begin miss++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, acc_addr[i], exp_a[i]); end
      vec++; if (pop_data[i] !== exp_d[i]) begin miss++; $display("FAIL wrap_data[%0d]: got %h want %h", i, pop_data[i], exp_d[i]); end
    end
    vec++; if (n_done != 1) begin miss++; $display("FAIL wrap_done_count: got %0d want 1", n_done); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL wrap_busy_after: got %b want 0", bus.busy); end
    $display("wrap: addresses wrapped past 0xFFFFFFFC, second start ignored, %0d reads", n_acc);
  endtask

  task automatic test_reset_midflight();
    clear_log();
    bus.data_ready = 1'b0;
    do_start(32'h5000, 19'd4);
    idle(1);
    vec++; if (bus.avm_avalonmaster_read !== 1'b1) begin miss++; $display("FAIL midrst_read_before: got %b want 1", bus.avm_avalonmaster_read); end
    rst_n = 1'b0;
    #1;
    vec++; if (bus.avm_avalonmaster_read !== 1'b0) begin miss++; $display("FAIL midrst_read: got %b want 0", bus.avm_avalonmaster_read); end
    vec++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    vec++; if (bus.data_valid !== 1'b0) begin miss++; $display("FAIL midrst_valid: got %b want 0", bus.data_valid); end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    $display("reset_midflight: read dropped on asynchronous reset");
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.data_ready = 1'b1;
    bus.avm_avalonmaster_waitrequest = 1'b0;
    clear_log();
    test_reset();
    test_basic_stream();
    test_waitrequest_stall();
    test_backpressure();
    test_zero_count();
    test_abort_stalled();
    test_wrap_and_restart();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
